stopwatch_timer: RTL and testbench
==================================

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count resolution in Hz (100 = centiseconds).
REQ-003 SHALL have port CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_stop  in  1  one-cycle pulse, toggles run/pause.
REQ-006 SHALL have port clear  in  1  one-cycle pulse, zero and stop.
REQ-007 SHALL have port lap  in  1  one-cycle pulse, toggles display hold.
REQ-008 SHALL have port running  out  1  high while counting.
REQ-009 SHALL have port wrap  out  1  one-cycle pulse on 59:59.99 -> 00:00.00 rollover.
REQ-010 SHALL have port bcd  out  24  displayed digits {m1,m0,s1,s0,c1,c0}, 4 bits each, m1 in MSBs.
REQ-011 SHALL have ports HEX5..HEX0  out  7 each  active-low segment codes, HEX5 = m1 ... HEX0 = c0.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE; running = (state == RUN).
REQ-013 SHALL transition on start_stop: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-014 SHALL, on clear in any state, go to IDLE, zero all digits and prescaler, release hold; clear beats start_stop and lap in the same cycle.
REQ-015 SHALL run a prescaler 0..CLK_HZ/TICK_HZ-1 only in RUN; tick asserts on terminal count; prescaler holds its value in PAUSE (no tick loss on resume).
REQ-016 SHALL cascade digits on the tick edge: c0 0-9, c1 0-9, s0 0-9, s1 0-5, m0 0-9, m1 0-5; all carries resolve in that same edge.
REQ-017 SHALL, on tick at 59:59.99, load 00:00.00, stay in RUN, and assert wrap for exactly that following cycle.
REQ-018 SHALL drive bcd from live digit registers (or hold register, REQ-024), zero added latency; HEX outputs combinational decode of bcd.
REQ-019 SHALL decode 0-9 to standard active-low patterns (0 = 7'b1000000, 8 = 7'b0000000); codes 10-15 blank (7'b1111111).
REQ-020 SHALL require CLK_HZ divisible by TICK_HZ with ratio >= 2; prescaler width = clog2(ratio).

Reset
REQ-021 SHALL, with rst high at a rising edge: state IDLE, digits 0, prescaler 0, hold off, wrap 0, running 0, bcd 0, all HEX = 7'b1000000.
REQ-022 SHALL let rst override every other input, including mid-count and during hold.

Configuration
REQ-023 SHALL compile lap logic only when STOPWATCH_LAP_EN is defined.
REQ-024 SHALL, with STOPWATCH_LAP_EN: lap in RUN or PAUSE toggles hold; entering hold copies live digits into a hold register shown on bcd while counting continues; leaving hold shows live digits; lap ignored in IDLE.
REQ-025 SHALL, without STOPWATCH_LAP_EN: no hold register, lap ignored, bcd always live.

Structure
REQ-026 SHALL place state enum, digit-limit constants and segment code table in package stopwatch_pkg.
REQ-027 SHALL instantiate sub-module hex_decoder (4-bit digit -> 7-bit active-low segments) six times.

Verification (CLK_HZ=1000, TICK_HZ=100, ratio 10)
REQ-028 SHALL test: rst, start_stop -> running=1 next cycle; after 10 cycles bcd=0x000001; after 1000 cycles bcd=0x000100.
REQ-029 SHALL test: start, 55 cycles, start_stop, idle 200 cycles -> bcd stays 0x000005; start_stop -> next tick after 5 cycles, bcd=0x000006.
REQ-030 SHALL test: run 3,599,990 cycles to 0x595999, one more tick -> bcd=0x000000, wrap=1 for one cycle, running=1.
REQ-031 SHALL test (LAP_EN): lap at 0x000050 -> bcd holds 0x000050 for 700 cycles; second lap -> bcd=0x000120 live.
REQ-032 SHALL test: clear and start_stop same cycle in RUN -> IDLE, bcd=0, running=0, HEX all 7'b1000000.
REQ-033 SHALL test: rst asserted during hold in RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states, per-digit limits and the segment table.
// Optional lap/hold display is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int NUM_DIGITS = 6;

    // Index 0 is c0 (hundredths), index 5 is m1 (tens of minutes).
    localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    // Active-low gfedcba patterns; codes 10-15 are blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        {6{7'b1111111}},
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/hex_decoder.sv
// One BCD digit to an active-low seven-segment pattern; purely combinational.
module hex_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/stopwatch_timer.sv
// MM:SS.cc stopwatch with run/pause/clear control, rollover pulse and six seven-segment outputs.
// Define STOPWATCH_LAP_EN to build the lap (display hold) feature.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic        running,
    output logic        wrap,
    output logic [23:0] bcd,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    localparam int              RATIO   = CLK_HZ / TICK_HZ;
    localparam int              PRE_W   = $clog2(RATIO);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RATIO - 1);

    sw_state_t                   state_reg, state_next;
    logic [PRE_W-1:0]            pre_reg, pre_next;
    logic [NUM_DIGITS-1:0][3:0]  digit_reg, digit_next;
    logic [NUM_DIGITS:0]         carry;
    logic                        wrap_reg, wrap_next;
    logic                        tick;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pre_reg   <= '0;
            digit_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
            digit_reg <= digit_next;
            wrap_reg  <= wrap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_IDLE;
        end else if (start_stop) begin
            case (state_reg)
                ST_IDLE:  state_next = ST_RUN;
                ST_RUN:   state_next = ST_PAUSE;
                ST_PAUSE: state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Prescaler only advances in RUN, so a pause keeps the partial tick.
    assign tick = (state_reg == ST_RUN) && (pre_reg == PRE_MAX);

    always_comb begin
        pre_next = pre_reg;
        if (clear)
            pre_next = '0;
        else if (tick)
            pre_next = '0;
        else if (state_reg == ST_RUN)
            pre_next = pre_reg + PRE_W'(1);
    end

    // Ripple carry through all six digits within the same tick edge.
    assign carry[0] = tick;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic at_max;
            assign at_max       = (digit_reg[gi] == DIGIT_MAX[gi]);
            assign carry[gi+1]  = carry[gi] && at_max;
            assign digit_next[gi] = clear    ? 4'd0 :
                                    carry[gi] ? (at_max ? 4'd0 : digit_reg[gi] + 4'd1) :
                                                digit_reg[gi];
        end
    endgenerate

    assign wrap_next = carry[NUM_DIGITS] && !clear;
    assign wrap      = wrap_reg;
    assign running   = (state_reg == ST_RUN);

`ifdef STOPWATCH_LAP_EN
    logic                       hold_reg, hold_next;
    logic [NUM_DIGITS-1:0][3:0] hold_digits_reg;

    always_comb begin
        hold_next = hold_reg;
        if (clear)
            hold_next = 1'b0;
        else if (lap && state_reg != ST_IDLE)
            hold_next = !hold_reg;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            hold_reg        <= 1'b0;
            hold_digits_reg <= '0;
        end else begin
            hold_reg <= hold_next;
            if (hold_next && !hold_reg)
                hold_digits_reg <= digit_reg;
        end
    end

    assign bcd = hold_reg ? hold_digits_reg : digit_reg;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign bcd        = digit_reg;
`endif

    logic [NUM_DIGITS-1:0][6:0] seg;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hex
            hex_decoder u_hex (
                .digit (bcd[gi*4 +: 4]),
                .seg   (seg[gi])
            );
        end
    endgenerate

    assign HEX0 = seg[0];
    assign HEX1 = seg[1];
    assign HEX2 = seg[2];
    assign HEX3 = seg[3];
    assign HEX4 = seg[4];
    assign HEX5 = seg[5];

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer at CLK_HZ=1000, TICK_HZ=100 (one tick every 10 clocks).
// Lap checks adapt to whether STOPWATCH_LAP_EN is defined for the build.
module tb_stopwatch_timer;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic        running, wrap;
    logic [23:0] bcd;
    logic [6:0]  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG9 = 7'b0010000;

    stopwatch_timer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .running    (running),
        .wrap       (wrap),
        .bcd        (bcd),
        .HEX5       (HEX5),
        .HEX4       (HEX4),
        .HEX3       (HEX3),
        .HEX2       (HEX2),
        .HEX1       (HEX1),
        .HEX0       (HEX0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
    endtask

    task automatic test_reset();
        start_stop = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        start_stop = 1'b0;
        tests_run++;
        if ({running, wrap, bcd} !== 26'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: running=%b wrap=%b bcd=%06h, want 0 0 000000", running, wrap, bcd);
        end
        tests_run++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{SEG0}}) begin
            tests_failed++;
            $display("FAIL reset_hex: got %h, want %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{SEG0}});
        end
        $display("[TB] test_reset: bcd=%06h running=%b", bcd, running);
    endtask

    task automatic test_count();
        do_reset();
        pulse_start();
        tests_run++;
        if (running !== 1'b1) begin
            tests_failed++;
            $display("FAIL count_running: got %b, want 1", running);
        end
        step(9);
        tests_run++;
        if (bcd !== 24'h000000) begin
            tests_failed++;
            $display("FAIL count_before_tick: got %06h, want 000000", bcd);
        end
        step(1);
        tests_run++;
        if (bcd !== 24'h000001) begin
            tests_failed++;
            $display("FAIL count_first_tick: got %06h, want 000001", bcd);
        end
        step(990);
        tests_run++;
        if (bcd !== 24'h000100) begin
            tests_failed++;
            $display("FAIL count_1s: got %06h, want 000100", bcd);
        end
        tests_run++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {SEG0, SEG0, SEG0, SEG1, SEG0, SEG0}) begin
            tests_failed++;
            $display("FAIL count_hex: got %h, want %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
                     {SEG0, SEG0, SEG0, SEG1, SEG0, SEG0});
        end
        $display("[TB] test_count: bcd=%06h after 1000 cycles", bcd);
    endtask

    task automatic test_pause();
        do_reset();
        pulse_start();
        step(54);
        pulse_start();
        tests_run++;
        if (running !== 1'b0 || bcd !== 24'h000005) begin
            tests_failed++;
            $display("FAIL pause_enter: running=%b bcd=%06h, want 0 000005", running, bcd);
        end
        step(200);
        tests_run++;
        if (running !== 1'b0 || bcd !== 24'h000005) begin
            tests_failed++;
            $display("FAIL pause_hold: running=%b bcd=%06h, want 0 000005", running, bcd);
        end
        pulse_start();
        tests_run++;
        if (running !== 1'b1) begin
            tests_failed++;
            $display("FAIL pause_resume: running=%b, want 1", running);
        end
        step(4);
        tests_run++;
        if (bcd !== 24'h000005) begin
            tests_failed++;
            $display("FAIL resume_early: got %06h, want 000005", bcd);
        end
        step(1);
        tests_run++;
        if (bcd !== 24'h000006) begin
            tests_failed++;
            $display("FAIL resume_tick: got %06h, want 000006", bcd);
        end
        $display("[TB] test_pause: bcd=%06h after resume", bcd);
    endtask

    // Preload 59:59.99 while paused instead of counting 3.6M cycles.
    task automatic test_wrap();
        do_reset();
        pulse_start();
        step(2);
        pulse_start();
        force dut.digit_reg = 24'h595999;
        step(1);
        release dut.digit_reg;
        tests_run++;
        if (bcd !== 24'h595999 || HEX5 !== SEG5 || HEX4 !== SEG9) begin
            tests_failed++;
            $display("FAIL wrap_preload: bcd=%06h HEX5=%b HEX4=%b, want 595999 %b %b", bcd, HEX5, HEX4, SEG5, SEG9);
        end
        pulse_start();
        step(6);
        tests_run++;
        if (bcd !== 24'h595999 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_pre_tick: bcd=%06h wrap=%b, want 595999 0", bcd, wrap);
        end
        step(1);
        tests_run++;
        if (bcd !== 24'h000000 || wrap !== 1'b1 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_rollover: bcd=%06h wrap=%b running=%b, want 000000 1 1", bcd, wrap, running);
        end
        step(1);
        tests_run++;
        if (wrap !== 1'b0 || bcd !== 24'h000000) begin
            tests_failed++;
            $display("FAIL wrap_one_cycle: wrap=%b bcd=%06h, want 0 000000", wrap, bcd);
        end
        $display("[TB] test_wrap: rollover to %06h", bcd);
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        do_reset();
        pulse_lap();
        pulse_start();
        step(500);
        tests_run++;
        if (bcd !== 24'h000050) begin
            tests_failed++;
            $display("FAIL lap_pre: got %06h, want 000050", bcd);
        end
        pulse_lap();
        step(99);
        tests_run++;
        if (bcd !== 24'h000050) begin
            tests_failed++;
            $display("FAIL lap_hold_early: got %06h, want 000050", bcd);
        end
        step(600);
        tests_run++;
        if (bcd !== 24'h000050 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL lap_hold_late: bcd=%06h running=%b, want 000050 1", bcd, running);
        end
        pulse_lap();
        tests_run++;
        if (bcd !== 24'h000120) begin
            tests_failed++;
            $display("FAIL lap_release: got %06h, want 000120", bcd);
        end
        $display("[TB] test_lap: live bcd=%06h after release", bcd);
    endtask
`else
    task automatic test_lap();
        do_reset();
        pulse_start();
        step(500);
        pulse_lap();
        step(99);
        tests_run++;
        if (bcd !== 24'h000060) begin
            tests_failed++;
            $display("FAIL lap_ignored: got %06h, want 000060", bcd);
        end
        $display("[TB] test_lap: lap ignored, bcd=%06h", bcd);
    endtask
`endif

    task automatic test_clear();
        do_reset();
        pulse_start();
        step(30);
        clear = 1'b1;
        start_stop = 1'b1;
        step(1);
        clear = 1'b0;
        start_stop = 1'b0;
        tests_run++;
        if (running !== 1'b0 || bcd !== 24'h0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_wins: running=%b bcd=%06h wrap=%b, want 0 000000 0", running, bcd, wrap);
        end
        tests_run++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{SEG0}}) begin
            tests_failed++;
            $display("FAIL clear_hex: got %h, want %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{SEG0}});
        end
        step(20);
        tests_run++;
        if (running !== 1'b0 || bcd !== 24'h0) begin
            tests_failed++;
            $display("FAIL clear_idle: running=%b bcd=%06h, want 0 000000", running, bcd);
        end
        pulse_start();
        step(10);
        tests_run++;
        if (bcd !== 24'h000001) begin
            tests_failed++;
            $display("FAIL clear_prescaler: got %06h, want 000001", bcd);
        end
        $display("[TB] test_clear: bcd=%06h after restart", bcd);
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        step(25);
        pulse_lap();
        step(40);
        rst = 1'b1;
        start_stop = 1'b1;
        lap = 1'b1;
        step(1);
        rst = 1'b0;
        start_stop = 1'b0;
        lap = 1'b0;
        tests_run++;
        if ({running, wrap, bcd} !== 26'h0 || {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{SEG0}}) begin
            tests_failed++;
            $display("FAIL reset_mid: running=%b wrap=%b bcd=%06h hex=%h, want all reset values",
                     running, wrap, bcd, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
        end
        pulse_start();
        step(10);
        tests_run++;
        if (bcd !== 24'h000001) begin
            tests_failed++;
            $display("FAIL reset_mid_live: got %06h, want 000001", bcd);
        end
        $display("[TB] test_reset_mid: bcd=%06h after restart", bcd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count();
        test_pause();
        test_wrap();
        test_lap();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
